// File: rtl/punc_mem_bridge_pkg.sv
// Shared definitions for the PUnC memory bridge:
// FSM state encoding and default parameter values.
package punc_mem_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          TIMEOUT_DEF  = 255;
  localparam logic [15:0] ERR_DATA_DEF = 16'h0000;
  localparam int          CNT_W        = 10;

endpackage

// File: rtl/punc_mem_bridge.sv
// Bridges the single-cycle PUnC datapath memory port onto a
// req/gnt/rvalid memory, stalling the core for the access.
module punc_mem_bridge
  import punc_mem_defs::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_r_req,
  input  logic [ADDR_W-1:0] core_r_addr,
  input  logic              core_w_en,
  input  logic [ADDR_W-1:0] core_w_addr,
  input  logic [DATA_W-1:0] core_w_data,
  output logic [DATA_W-1:0] core_r_data,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam logic [CNT_W-1:0] TO_L = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_busy;
  logic              w_hit;
  logic              w_spent;
  logic              w_cap_w;
  logic              w_cap_r;
  logic              w_gnt;
  logic              w_rd_done;
  logic              w_tout;

  assign w_busy    = (r_state == REQ) || (r_state == WAIT_R);
  assign w_cnt_nxt = r_cnt + ONE;
  assign w_hit     = (w_cnt_nxt == TO_L);
  // A grant in the last budget cycle leaves nothing for the read data.
  assign w_spent   = (r_cnt == TO_L);

  always_comb begin
    w_state_nxt = r_state;
    w_cap_w     = 1'b0;
    w_cap_r     = 1'b0;
    w_gnt       = 1'b0;
    w_rd_done   = 1'b0;
    w_tout      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (core_w_en) begin
          w_cap_w     = 1'b1;
          w_state_nxt = REQ;
        end else if (core_r_req) begin
          w_cap_r     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          w_gnt       = 1'b1;
          w_state_nxt = r_we ? DONE : WAIT_R;
        end else if (w_hit) begin
          w_tout      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      WAIT_R: begin
        if (w_spent) begin
          w_tout      = 1'b1;
          w_state_nxt = DONE;
        end else if (mem_rvalid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = DONE;
        end else if (w_hit) begin
          w_tout      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_cap_w) begin
        r_req   <= 1'b1;
        r_we    <= 1'b1;
        r_addr  <= core_w_addr;
        r_wdata <= core_w_data;
        r_cnt   <= '0;
      end else if (w_cap_r) begin
        r_req  <= 1'b1;
        r_we   <= 1'b0;
        r_addr <= core_r_addr;
        r_cnt  <= '0;
      end else if (w_busy && !w_spent) begin
        r_cnt <= w_cnt_nxt;
      end
      if (w_gnt) r_req <= 1'b0;
      if (w_rd_done) r_rdata <= mem_rdata;
      if (w_tout) begin
        r_err <= 1'b1;
        r_req <= 1'b0;
        if (!r_we) r_rdata <= ERR_DATA;
      end
    end
  end

  assign core_stall  = ((r_state == IDLE) && (core_r_req || core_w_en))
                     || w_busy;
  assign core_r_data = r_rdata;
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign err         = r_err;

endmodule

// File: tb/tb_punc_mem_bridge.sv
// Directed vector table plus randomized transactions checked
// against a budget-arithmetic model of the bridge.
module tb_punc_mem_bridge;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        core_r_req;
  logic [15:0] core_r_addr;
  logic        core_w_en;
  logic [15:0] core_w_addr;
  logic [15:0] core_w_data;
  logic [15:0] core_r_data;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  punc_mem_bridge #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TMO),
    .ERR_DATA(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_r_req (core_r_req),
    .core_r_addr(core_r_addr),
    .core_w_en  (core_w_en),
    .core_w_addr(core_w_addr),
    .core_w_data(core_w_data),
    .core_r_data(core_r_data),
    .core_stall (core_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rr;
    logic [15:0] ra;
    logic        we;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        g;
    logic        rv;
    logic [15:0] rd;
    logic        chk;
    logic        es;
    logic        eq;
    logic        ewe;
    logic [15:0] ea;
    logic [15:0] ewd;
    logic [15:0] erd;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input int r, rr, ra, we, wa, wd, g, rv, rd,
    input int c, es, eq, ewe, ea, ewd, erd, ee
  );
    vec_t v;
    v.rst = 1'(r);   v.rr = 1'(rr);  v.ra = 16'(ra);
    v.we = 1'(we);   v.wa = 16'(wa); v.wd = 16'(wd);
    v.g = 1'(g);     v.rv = 1'(rv);  v.rd = 16'(rd);
    v.chk = 1'(c);   v.es = 1'(es);  v.eq = 1'(eq);
    v.ewe = 1'(ewe); v.ea = 16'(ea); v.ewd = 16'(ewd);
    v.erd = 16'(erd); v.ee = 1'(ee);
    tbl.push_back(v);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, rr, input logic [15:0] ra,
                     input logic we, input logic [15:0] wa, wd,
                     input logic g, rv, input logic [15:0] rd);
    @(negedge clk);
    rst = r;
    core_r_req = rr;  core_r_addr = ra;
    core_w_en = we;   core_w_addr = wa; core_w_data = wd;
    mem_gnt = g;      mem_rvalid = rv;  mem_rdata = rd;
    #1;
  endtask

  int          op, dg, dr, req_n, act_n, k;
  bit          is_w, rq, wq, tmo, hold;
  logic [15:0] ra, wa, wd, rd;
  logic [15:0] exp_rdata;
  logic        exp_err;
  string       pf;

  initial begin
    rst = 1'b1;
    core_r_req = 0; core_r_addr = 0; core_w_en = 0;
    core_w_addr = 0; core_w_data = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    // reset, then read with immediate grant
    add(1,0,0,0,0,0,0,0,0,           0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,           1, 0,0,0,0,0,0,0);
    add(0,1,'h3000,0,0,0,0,0,0,      1, 1,0,0,0,0,0,0);
    add(0,1,'h3000,0,0,0,1,0,0,      1, 1,1,0,'h3000,0,0,0);
    add(0,1,'h3000,0,0,0,0,1,'h1234, 1, 1,0,0,'h3000,0,0,0);
    add(0,1,'h3000,0,0,0,0,0,0,      1, 0,0,0,'h3000,0,'h1234,0);
    add(0,0,0,0,0,0,0,0,0,           1, 0,0,0,'h3000,0,'h1234,0);
    // write, grant after 3 cycles, core inputs wiggle after capture
    add(0,0,0,1,'h4001,'hBEEF,0,0,0, 1, 1,0,0,'h3000,0,'h1234,0);
    add(0,0,0,1,'hFFFF,'h0000,0,0,0, 1, 1,1,1,'h4001,'hBEEF,'h1234,0);
    add(0,0,0,1,'h1111,'h2222,0,0,0, 1, 1,1,1,'h4001,'hBEEF,'h1234,0);
    add(0,0,0,1,'h4001,'hBEEF,1,0,0, 1, 1,1,1,'h4001,'hBEEF,'h1234,0);
    add(0,0,0,1,'h4001,'hBEEF,0,0,0, 1, 0,0,1,'h4001,'hBEEF,'h1234,0);
    add(0,0,0,0,0,0,0,0,0,           1, 0,0,1,'h4001,'hBEEF,'h1234,0);
    // simultaneous write and read
    add(0,1,'h20,1,'h10,'h5555,0,0,0, 1, 1,0,1,'h4001,'hBEEF,'h1234,0);
    add(0,1,'h20,1,'h10,'h5555,1,0,0, 1, 1,1,1,'h10,'h5555,'h1234,0);
    add(0,1,'h20,1,'h10,'h5555,0,0,0, 1, 0,0,1,'h10,'h5555,'h1234,0);
    add(0,1,'h20,0,0,0,0,0,0,         1, 1,0,1,'h10,'h5555,'h1234,0);
    add(0,1,'h20,0,0,0,1,0,0,         1, 1,1,0,'h20,'h5555,'h1234,0);
    add(0,1,'h20,0,0,0,0,1,'h0F0F,    1, 1,0,0,'h20,'h5555,'h1234,0);
    add(0,1,'h20,0,0,0,0,0,0,         1, 0,0,0,'h20,'h5555,'h0F0F,0);
    add(0,0,0,0,0,0,0,0,0,            1, 0,0,0,'h20,'h5555,'h0F0F,0);
    // read timeout, grant never comes
    add(0,1,'h123,0,0,0,0,0,0,        1, 1,0,0,'h20,'h5555,'h0F0F,0);
    for (int i = 0; i < TMO; i++)
      add(0,1,'h123,0,0,0,0,0,0,      1, 1,1,0,'h123,'h5555,'h0F0F,0);
    add(0,1,'h123,0,0,0,0,0,0,        1, 0,0,0,'h123,'h5555,0,1);
    add(0,0,0,0,0,0,0,0,0,            1, 0,0,0,'h123,'h5555,0,1);
    // normal read afterwards, err stays set
    add(0,1,'h40,0,0,0,0,0,0,         1, 1,0,0,'h123,'h5555,0,1);
    add(0,1,'h40,0,0,0,1,0,0,         1, 1,1,0,'h40,'h5555,0,1);
    add(0,1,'h40,0,0,0,0,1,'h7777,    1, 1,0,0,'h40,'h5555,0,1);
    add(0,1,'h40,0,0,0,0,0,0,         1, 0,0,0,'h40,'h5555,'h7777,1);
    add(0,0,0,0,0,0,0,0,0,            1, 0,0,0,'h40,'h5555,'h7777,1);
    // reset mid WAIT_R, then a stray rvalid
    add(1,0,0,0,0,0,0,0,0,            1, 0,0,0,'h40,'h5555,'h7777,1);
    add(0,1,'h50,0,0,0,0,0,0,         1, 1,0,0,0,0,0,0);
    add(0,1,'h50,0,0,0,1,0,0,         1, 1,1,0,'h50,0,0,0);
    add(1,1,'h50,0,0,0,0,0,0,         1, 1,0,0,'h50,0,0,0);
    add(0,0,0,0,0,0,0,1,'hAAAA,       1, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,            1, 0,0,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].rst, tbl[i].rr, tbl[i].ra, tbl[i].we, tbl[i].wa,
          tbl[i].wd, tbl[i].g, tbl[i].rv, tbl[i].rd);
      if (tbl[i].chk) begin
        pf = $sformatf("vec%0d", i);
        chk1({pf, ".stall"}, core_stall, tbl[i].es);
        chk1({pf, ".req"}, mem_req, tbl[i].eq);
        chk1({pf, ".we"}, mem_we, tbl[i].ewe);
        chk16({pf, ".addr"}, mem_addr, tbl[i].ea);
        chk16({pf, ".wdata"}, mem_wdata, tbl[i].ewd);
        chk16({pf, ".rdata"}, core_r_data, tbl[i].erd);
        chk1({pf, ".err"}, err, tbl[i].ee);
      end
    end

    // randomized transactions; each access gets TMO cycles in REQ+WAIT_R
    exp_rdata = 16'h0000;
    exp_err   = 1'b0;
    for (int t = 0; t < 200; t++) begin
      op = $urandom_range(0, 2);
      dg = $urandom_range(0, 9);
      dr = $urandom_range(0, 4);
      ra = 16'($urandom); wa = 16'($urandom);
      wd = 16'($urandom); rd = 16'($urandom);
      rq = (op != 0);
      wq = (op != 1);
      is_w = wq;
      k = dg + 1 + dr;
      if (dg >= TMO) begin
        tmo = 1; req_n = TMO; act_n = TMO;
      end else if (is_w) begin
        tmo = 0; req_n = dg + 1; act_n = dg + 1;
      end else if (k < TMO) begin
        tmo = 0; req_n = dg + 1; act_n = k + 1;
      end else begin
        tmo = 1; req_n = dg + 1;
        act_n = (dg + 2 > TMO) ? dg + 2 : TMO;
      end
      for (int c = 0; c <= act_n + 2; c++) begin
        pf = $sformatf("rnd%0d.c%0d", t, c);
        if (c == 0) begin
          drv(0, rq, ra, wq, wa, wd, 0, 0, 16'($urandom));
        end else if (c <= act_n) begin
          drv(0, rq, 16'($urandom), wq, 16'($urandom), 16'($urandom),
              c == 1 + dg, !is_w && (c == 1 + k),
              (!is_w && (c == 1 + k)) ? rd : 16'($urandom));
        end else if (c == act_n + 1) begin
          hold = 1'($urandom_range(0, 1));
          drv(0, hold & rq, 16'($urandom), hold & wq, 16'($urandom),
              16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
          if (tmo) exp_err = 1'b1;
          if (!is_w) exp_rdata = tmo ? 16'h0000 : rd;
        end else begin
          drv(0, 0, 16'($urandom), 0, 16'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 16'($urandom));
        end
        chk1({pf, ".stall"}, core_stall, c <= act_n);
        chk1({pf, ".req"}, mem_req, (c >= 1) && (c <= req_n));
        if (c >= 1 && c <= req_n) begin
          chk1({pf, ".we"}, mem_we, is_w);
          chk16({pf, ".addr"}, mem_addr, is_w ? wa : ra);
          if (is_w) chk16({pf, ".wdata"}, mem_wdata, wd);
        end
        chk16({pf, ".rdata"}, core_r_data, exp_rdata);
        chk1({pf, ".err"}, err, exp_err);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
